// File: rtl/dram_bist_top_if.sv
// Board-facing pin bundle for dram_bist_top.
//   rx  : UART loopback input
//   tx  : UART loopback output (mirrors rx)
//   sw  : slide switches (manual address/data/WE, BIST controls)
//   led : RAM read data and BIST status
// master = board/testbench side, slave = design side.
interface dram_bist_top_if;
    logic        rx;
    logic        tx;
    logic [15:0] sw;
    logic [15:0] led;

    modport master (output rx, output sw, input tx, input led);
    modport slave  (input rx, input sw, output tx, output led);
endinterface

// File: rtl/dram_bist_top.sv
// Distributed-RAM board test top. CHANNELS single-port 2**ADDR_WIDTH x 1
// LUT-RAMs share address and write enable. They are driven either from the
// switches or by a BIST sequencer that writes a checkerboard and reads it back.
//   clk : sole clock, RAM writes on rising edge
//   rst : asynchronous active-high reset (status/FSM only, RAM contents kept)
//   bus : rx/tx loopback, sw[15:0] controls, led[15:0] data and status
//         led[CHANNELS-1:0] read data, [11:4] error count, [12] error,
//         [13] pass, [14] done, [15] busy
module dram_bist_top #(
    parameter int ADDR_WIDTH = 6,
    parameter int CHANNELS   = 4,
    parameter logic [(2**ADDR_WIDTH)-1:0] INIT = 64'h2
) (
    input  logic           clk,
    input  logic           rst,
    dram_bist_top_if.slave bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                state;
    logic [2:0]            sync1, sync2;   // {start, pattern, inject}
    logic                  start_d;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [7:0]            err_cnt;
    logic                  error, pass, pat, inj;

    logic                  busy, start_edge, ram_we, mismatch;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [CHANNELS-1:0]   rd_data, wr_data, exp_data;
    logic [7:0]            err_next;
    logic [15:0]           led_w;
    logic                  unused_sw;

    assign busy       = (state == WRITE) || (state == READ);
    assign start_edge = sync2[2] & ~start_d;

    // FSM owns the RAM port while busy; otherwise the switches do.
    assign ram_addr = busy ? cnt : bus.sw[ADDR_WIDTH-1:0];
    assign ram_we   = (state == WRITE) || (!busy && bus.sw[15]);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DEPTH-1:0] mem = INIT;

        // Odd channels carry the inverted phase of the checkerboard.
        assign exp_data[c] = cnt[0] ^ pat ^ ((c % 2) == 1);
        assign wr_data[c]  = (state == WRITE)
                           ? (exp_data[c] ^ (inj && (cnt == '0) && (c == 0)))
                           : bus.sw[11+c];

        // No write while rst is asserted so a reset cannot leave a stray bit.
        always_ff @(posedge clk)
            if (ram_we && !rst)
                mem[ram_addr] <= wr_data[c];

        assign rd_data[c] = mem[ram_addr];
    end

    assign mismatch = |(rd_data ^ exp_data);
    assign err_next = (mismatch && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            start_d <= 1'b0;
        end else begin
            sync1   <= bus.sw[10:8];
            sync2   <= sync1;
            start_d <= sync2[2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            err_cnt <= '0;
            error   <= 1'b0;
            pass    <= 1'b0;
            pat     <= 1'b0;
            inj     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        state   <= WRITE;
                        cnt     <= '0;
                        err_cnt <= '0;
                        error   <= 1'b0;
                        pass    <= 1'b0;
                        pat     <= sync2[1];
                        inj     <= sync2[0];
                    end
                end
                WRITE: begin
                    cnt <= cnt + 1'b1;          // wraps to 0 for READ
                    if (cnt == '1)
                        state <= READ;
                end
                READ: begin
                    cnt     <= cnt + 1'b1;
                    err_cnt <= err_next;
                    if (mismatch)
                        error <= 1'b1;
                    if (cnt == '1) begin
                        state <= DONE;
                        pass  <= (err_next == 8'd0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        led_w                 = '0;
        led_w[CHANNELS-1:0]   = rd_data;
        led_w[11:4]           = err_cnt;
        led_w[12]             = error;
        led_w[13]             = pass;
        led_w[14]             = (state == DONE);
        led_w[15]             = busy;
    end

    assign bus.led = led_w;
    assign bus.tx  = bus.rx;

    // Address bits above ADDR_WIDTH and data switches of absent channels.
    assign unused_sw = ^bus.sw;
endmodule

// File: tb/tb_dram_bist_top.sv
module tb_dram_bist_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   npass = 0;
    int   ntotal = 0;

    dram_bist_top_if bus();

    dram_bist_top #(.ADDR_WIDTH(6), .CHANNELS(4), .INIT(64'h2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] led;
        logic        tx;
    } exp_t;

    typedef struct {
        string       name;
        logic [15:0] sw;
        logic        rx;
        logic [15:0] led;
        logic        tx;
    } vec_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected RAM word for the checkerboard: channel c = a[0]^c[0]^p.
    function automatic logic [3:0] patv(input int a, input bit p);
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = a[0] ^ c[0] ^ p;
        return v;
    endfunction

    // Drive one vector after a rising edge, queue its expectation, compare
    // at the following falling edge.
    task automatic apply(input string name, input logic [15:0] sw, input logic rx,
                         input logic [15:0] led, input logic tx);
        exp_t e;
        @(posedge clk); #1;
        bus.sw = sw;
        bus.rx = rx;
        sb.push_back('{name, led, tx});
        @(negedge clk);
        e = sb.pop_front();
        chk({e.name, "_led"}, bus.led, e.led);
        chk({e.name, "_tx"}, {15'd0, bus.tx}, {15'd0, e.tx});
    endtask

    // Launch a BIST run and count busy cycles until done.
    task automatic run_bist(input string name, input bit pat, input bit inj,
                            input bit noisy, output int nbusy);
        bit fin = 0;
        nbusy = 0;
        bus.sw = 16'h0400 | (16'(pat) << 9) | (16'(inj) << 8);
        for (int i = 0; i < 400 && !fin; i++) begin
            @(negedge clk);
            if (bus.led[15]) begin
                nbusy++;
                if (!noisy) bus.sw[10] = 1'b0;
                else if (nbusy < 100) begin
                    bus.sw[10]    = nbusy[2];
                    bus.sw[15]    = 1'b1;
                    bus.sw[14:11] = 4'b0000;
                end else begin
                    bus.sw[10] = 1'b0;
                    bus.sw[15] = 1'b0;
                end
            end else if (bus.led[14] && nbusy > 0) fin = 1;
        end
        if (!fin) begin
            ntotal++;
            $display("FAIL %s_timeout: got no done, expected done within 400 cycles", name);
        end
        chk({name, "_busy_cycles"}, 16'(nbusy), 16'd128);
    endtask

    vec_t vt[10];
    int   nb;

    initial begin
        bus.sw = '0;
        bus.rx = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_led", bus.led, 16'h0000);
        @(negedge clk); rst = 1'b0;

        // INIT, loopback and manual write/readback
        vt[0] = '{"init_a0",    16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[1] = '{"init_a1",    16'h0001, 1'b1, 16'h000F, 1'b1};
        vt[2] = '{"init_a2",    16'h0002, 1'b0, 16'h0000, 1'b0};
        vt[3] = '{"wr5_pre",    16'hD005, 1'b1, 16'h0000, 1'b1};
        vt[4] = '{"rd5",        16'h0005, 1'b0, 16'h000A, 1'b0};
        vt[5] = '{"wr6_pre",    16'hA806, 1'b1, 16'h0000, 1'b1};
        vt[6] = '{"rd6",        16'h0006, 1'b0, 16'h0005, 1'b0};
        vt[7] = '{"rd5_kept",   16'h0005, 1'b1, 16'h000A, 1'b1};
        vt[8] = '{"rd1_kept",   16'h0001, 1'b0, 16'h000F, 1'b0};
        vt[9] = '{"rd0_kept",   16'h0000, 1'b0, 16'h0000, 1'b0};
        foreach (vt[i]) apply(vt[i].name, vt[i].sw, vt[i].rx, vt[i].led, vt[i].tx);

        // BIST pass, pat = 0
        run_bist("bist0", 1'b0, 1'b0, 1'b0, nb);
        apply("bist0_a1", 16'h0001, 1'b0, 16'h6000 | 16'(patv(1, 0)), 1'b0);
        apply("bist0_a0", 16'h0000, 1'b0, 16'h6000 | 16'(patv(0, 0)), 1'b0);

        // Fault inject: one error at address 0, channel 0
        run_bist("inject", 1'b0, 1'b1, 1'b0, nb);
        apply("inject_a0", 16'h0000, 1'b0, 16'h501B, 1'b0);
        apply("inject_a1", 16'h0001, 1'b0, 16'h5015, 1'b0);
        apply("inject_a2", 16'h0002, 1'b0, 16'h501A, 1'b0);

        // Reset 40 cycles into WRITE
        @(posedge clk); #1;
        bus.sw = 16'h0400;
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                seen = bus.led[15];
            end
            if (!seen) begin
                ntotal++;
                $display("FAIL midrst_start: got busy=0, expected busy=1");
            end
        end
        repeat (40) @(negedge clk);
        rst = 1'b1;
        bus.sw = 16'h0000;
        #1;
        chk("midrst_immediate", bus.led, 16'h000A);
        @(negedge clk);
        chk("midrst_held", bus.led, 16'h000A);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle", bus.led, 16'h000A);

        run_bist("bist1", 1'b1, 1'b0, 1'b0, nb);
        apply("bist1_a0", 16'h0000, 1'b0, 16'h6005, 1'b0);
        apply("bist1_a1", 16'h0001, 1'b0, 16'h600A, 1'b0);

        // Start toggles and manual WE during busy are ignored
        @(posedge clk); #1;
        run_bist("noisy", 1'b0, 1'b0, 1'b1, nb);
        repeat (10) @(negedge clk);
        chk("noisy_single_run", bus.led & 16'hFFF0, 16'h6000);
        apply("noisy_a0",  16'h0000, 1'b0, 16'h6000 | 16'(patv(0, 0)),  1'b0);
        apply("noisy_a1",  16'h0001, 1'b1, 16'h6000 | 16'(patv(1, 0)),  1'b1);
        apply("noisy_a2",  16'h0002, 1'b0, 16'h6000 | 16'(patv(2, 0)),  1'b0);
        apply("noisy_a62", 16'h003E, 1'b0, 16'h6000 | 16'(patv(62, 0)), 1'b0);
        apply("noisy_a63", 16'h003F, 1'b0, 16'h6000 | 16'(patv(63, 0)), 1'b0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
